// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, owner encoding,
// default widths and the address bit that selects the IO space.
package dmem_pkg;

    localparam int RAM_AW_DEFAULT = 14;
    localparam int DW_DEFAULT     = 32;
    localparam int IO_SEL_BIT     = 31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0] = CPU, req[1] = loader. On a tie the port
// that was not granted last wins; the history only moves when advance is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = loader received the most recent grant; reset value lets the CPU win the first tie.
    logic last_ldr;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_ldr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ldr <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_ldr <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port RAM between the CPU and the loader, and
// decodes CPU accesses with address bit 31 set into the switch/LED IO space.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT,
    parameter int DW     = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic              cpu_ready,
    output logic [DW-1:0]     cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [RAM_AW-1:0] ldr_addr,
    input  logic [DW-1:0]     ldr_wdata,
    output logic              ldr_ready,
    output logic [DW-1:0]     ldr_rdata,

    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_dout,

    input  logic [15:0]       io_switch,
    output logic [15:0]       led,

    output state_t            fsm_state
);

    // Handshake: a port raises req with we/addr/wdata stable and holds them until
    // its ready pulses for one cycle; rdata is valid with that pulse and is held
    // until the same port's next read completes.

    logic [1:0]        req_vec;
    logic [1:0]        gnt;
    logic              arb_advance;

    logic [RAM_AW-1:0] cpu_word;
    logic              cpu_io;

    logic              sel_we;
    logic              sel_io;
    logic [RAM_AW-1:0] sel_addr;
    logic [DW-1:0]     sel_wdata;

    owner_t            owner;
    logic              owner_we;
    logic              owner_io;

    logic              unused_addr_bits;

    assign req_vec     = {ldr_req, cpu_req};
    assign arb_advance = (fsm_state == S_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (arb_advance),
        .gnt     (gnt)
    );

    // Upper CPU address bits alias onto the RAM; byte offset is ignored.
    assign cpu_word         = cpu_addr[RAM_AW+1:2];
    assign cpu_io           = cpu_addr[IO_SEL_BIT];
    assign unused_addr_bits = ^{cpu_addr[IO_SEL_BIT-1:RAM_AW+2], cpu_addr[1:0]};

    always_comb begin
        sel_we    = cpu_we;
        sel_io    = cpu_io;
        sel_addr  = cpu_word;
        sel_wdata = cpu_wdata;
        if (gnt[1]) begin
            sel_we    = ldr_we;
            sel_io    = 1'b0;
            sel_addr  = ldr_addr;
            sel_wdata = ldr_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state <= S_IDLE;
            owner     <= OWN_CPU;
            owner_we  <= 1'b0;
            owner_io  <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            led       <= '0;
        end else begin
            cpu_ready <= 1'b0;
            ldr_ready <= 1'b0;
            ram_we    <= 1'b0;

            case (fsm_state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        owner     <= gnt[1] ? OWN_LDR : OWN_CPU;
                        owner_we  <= sel_we;
                        owner_io  <= sel_io;
                        ram_addr  <= sel_addr;
                        ram_din   <= sel_wdata;
                        // Registered here so the write strobe covers exactly the ACCESS cycle.
                        ram_we    <= sel_we & ~sel_io;
                        fsm_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (owner_io) begin
                        if (owner_we) begin
                            led <= ram_din[15:0];
                        end else if (owner == OWN_LDR) begin
                            ldr_rdata <= {{(DW-16){1'b0}}, io_switch};
                        end else begin
                            cpu_rdata <= {{(DW-16){1'b0}}, io_switch};
                        end
                    end

                    if (owner_io || owner_we) begin
                        cpu_ready <= (owner == OWN_CPU);
                        ldr_ready <= (owner == OWN_LDR);
                        fsm_state <= S_DONE;
                    end else begin
                        fsm_state <= S_RDWAIT;
                    end
                end

                S_RDWAIT: begin
                    if (owner == OWN_LDR) begin
                        ldr_rdata <= ram_dout;
                    end else begin
                        cpu_rdata <= ram_dout;
                    end
                    cpu_ready <= (owner == OWN_CPU);
                    ldr_ready <= (owner == OWN_LDR);
                    fsm_state <= S_DONE;
                end

                S_DONE: begin
                    fsm_state <= S_IDLE;
                end

                default: begin
                    fsm_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// concurrent CPU/loader traffic against a transaction-level memory/LED model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int RAM_AW = 14;
    localparam int DW     = 32;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic              cpu_ready;
    logic [DW-1:0]     cpu_rdata;
    logic              ldr_req;
    logic              ldr_we;
    logic [RAM_AW-1:0] ldr_addr;
    logic [DW-1:0]     ldr_wdata;
    logic              ldr_ready;
    logic [DW-1:0]     ldr_rdata;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_din;
    logic              ram_we;
    logic [DW-1:0]     ram_dout;
    logic [15:0]       io_switch;
    logic [15:0]       led;
    state_t            fsm_state;

    dmem_arbiter #(.RAM_AW(RAM_AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ready (ldr_ready),
        .ldr_rdata (ldr_rdata),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .io_switch (io_switch),
        .led       (led),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- synchronous RAM model ----------------
    logic [DW-1:0] ram [0:(1<<RAM_AW)-1];
    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = '0;
    end
    always @(posedge clk) begin
        logic [DW-1:0] rd;
        rd = ram[ram_addr];
        if (ram_we) ram[ram_addr] = ram_din;
        ram_dout <= rd;
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ref_mem [int];
    logic [15:0]   led_exp;
    bit            cpu_hold_valid, ldr_hold_valid;
    logic [DW-1:0] cpu_hold_val, ldr_hold_val;
    logic [DW-1:0] exp_q[$];

    int            we_cnt = 0;
    logic [RAM_AW-1:0] we_addr;
    logic [DW-1:0] we_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_din;
        end
        if (cpu_ready || ldr_ready)
            check_val("ready_exclusive", {31'b0, cpu_ready & ldr_ready}, 32'd0);
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [15:0] sw, output int lat, output int done_cyc);
        int a;
        bit io, got;
        @(negedge clk);
        if (cpu_hold_valid) check_val("cpu_rdata_hold", cpu_rdata, cpu_hold_val);
        io = addr[31];
        a  = int'(addr[RAM_AW+1:2]);
        io_switch = sw;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            got = cpu_ready;
        end
        cpu_req  = 1'b0;
        done_cyc = cyc;
        if (!got) begin
            check_val("cpu_timeout", 32'd0, 32'd1);
            return;
        end
        if (we) begin
            if (io) begin
                led_exp = wdata[15:0];
                check_val("cpu_led", {16'h0, led}, {16'h0, led_exp});
            end else begin
                ref_mem[a] = wdata;
            end
            cpu_hold_valid = 1'b0;
        end else begin
            exp_q.push_back(io ? {16'h0, sw} : ref_rd(a));
            cpu_hold_val   = exp_q.pop_front();
            cpu_hold_valid = 1'b1;
            check_val("cpu_rdata", cpu_rdata, cpu_hold_val);
        end
    endtask

    task automatic ldr_txn(input logic we, input logic [RAM_AW-1:0] addr, input logic [31:0] wdata,
                           output int lat, output int done_cyc);
        bit got;
        @(negedge clk);
        if (ldr_hold_valid) check_val("ldr_rdata_hold", ldr_rdata, ldr_hold_val);
        ldr_we    = we;
        ldr_addr  = addr;
        ldr_wdata = wdata;
        ldr_req   = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            got = ldr_ready;
        end
        ldr_req  = 1'b0;
        done_cyc = cyc;
        if (!got) begin
            check_val("ldr_timeout", 32'd0, 32'd1);
            return;
        end
        if (we) begin
            ref_mem[int'(addr)] = wdata;
            ldr_hold_valid = 1'b0;
        end else begin
            ldr_hold_val   = ref_rd(int'(addr));
            ldr_hold_valid = 1'b1;
            check_val("ldr_rdata", ldr_rdata, ldr_hold_val);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        led_exp        = '0;
        cpu_hold_valid = 1'b1;
        cpu_hold_val   = '0;
        ldr_hold_valid = 1'b1;
        ldr_hold_val   = '0;
    endtask

    // ---------------- stimulus ----------------
    int lat, c1, c2, c3, c4, c5, w0, rdy_seen, rnd_writes;
    int r_cl, r_cc, r_ll, r_lc;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        io_switch = '0;
        led_exp = '0;
        cpu_hold_valid = 1'b1; cpu_hold_val = '0;
        ldr_hold_valid = 1'b1; ldr_hold_val = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_val("rst_state", 32'(fsm_state), 32'(S_IDLE));
        check_val("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check_val("rst_ready", {30'b0, cpu_ready, ldr_ready}, 32'd0);
        check_val("rst_led", {16'h0, led}, 32'd0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_val("rst_ldr_rdata", ldr_rdata, 32'd0);
        check_val("rst_ram_addr", 32'(ram_addr), 32'd0);
        rst = 1'b0;

        // CPU store then load at byte address 0x10
        w0 = we_cnt;
        cpu_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0, lat, c1);
        check_val("st_latency", lat, 32'd2);
        check_val("st_we_pulses", we_cnt - w0, 32'd1);
        check_val("st_we_addr", 32'(we_addr), 32'd4);
        check_val("st_we_data", we_data, 32'hDEAD_BEEF);
        cpu_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, lat, c1);
        check_val("ld_latency", lat, 32'd3);
        check_val("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests after reset: CPU, loader, then CPU re-request loses the tie
        apply_reset();
        fork
            begin
                cpu_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, lat, c1);
                cpu_txn(1'b0, 32'h0000_0020, 32'h0, 16'h0, r_cl, c3);
            end
            ldr_txn(1'b0, 14'h0004, 32'h0, r_ll, c2);
        join
        check_val("rr_cpu_first", {31'b0, c1 < c2}, 32'd1);
        check_val("rr_ldr_second", {31'b0, c2 < c3}, 32'd1);
        fork
            cpu_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, lat, c4);
            ldr_txn(1'b0, 14'h0004, 32'h0, r_ll, c5);
        join
        check_val("rr_repeat_ldr_first", {31'b0, c5 < c4}, 32'd1);

        // IO store / load
        w0 = we_cnt;
        cpu_txn(1'b1, 32'h8000_0000, 32'h1234_ABCD, 16'h0, lat, c1);
        check_val("io_st_latency", lat, 32'd2);
        check_val("io_led", {16'h0, led}, 32'h0000_ABCD);
        cpu_txn(1'b0, 32'h8000_0000, 32'h0, 16'h00F0, lat, c1);
        check_val("io_ld_latency", lat, 32'd2);
        check_val("io_ld_rdata", cpu_rdata, 32'h0000_00F0);
        check_val("io_no_ram_we", we_cnt - w0, 32'd0);

        // Top word from the loader, read back by the CPU directly and through an alias
        ldr_txn(1'b1, 14'h3FFF, 32'hCAFE_F00D, lat, c1);
        cpu_txn(1'b0, 32'h0000_FFFC, 32'h0, 16'h0, lat, c1);
        check_val("edge_rdata", cpu_rdata, 32'hCAFE_F00D);
        cpu_txn(1'b0, 32'h7FFE_FFFF, 32'h0, 16'h0, lat, c1);
        check_val("alias_rdata", cpu_rdata, 32'hCAFE_F00D);

        // Reset during RDWAIT aborts the read silently
        @(negedge clk);
        cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_rdwait", 32'(fsm_state), 32'(S_RDWAIT));
        rst = 1'b1;
        cpu_req = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ready || ldr_ready) rdy_seen++;
        end
        check_val("abort_led", {16'h0, led}, 32'd0);
        check_val("abort_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        led_exp = '0;
        cpu_hold_valid = 1'b1; cpu_hold_val = '0;
        ldr_hold_valid = 1'b1; ldr_hold_val = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_ready || ldr_ready) rdy_seen++;
        end
        check_val("abort_no_ready", rdy_seen, 32'd0);
        cpu_txn(1'b0, 32'h0000_0010, 32'h0, 16'h0, lat, c1);
        check_val("post_abort_latency", lat, 32'd3);
        check_val("post_abort_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Randomized concurrent traffic
        w0 = we_cnt;
        rnd_writes = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    bit we, io;
                    logic [RAM_AW-1:0] widx;
                    we   = 1'($urandom_range(0, 1));
                    io   = ($urandom_range(0, 3) == 0);
                    widx = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
                    if (we && !io) rnd_writes++;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    cpu_txn(we, {io, 15'($urandom), widx, 2'($urandom)}, $urandom,
                            16'($urandom), r_cl, r_cc);
                    check_val("cpu_wait_bound", {31'b0, r_cl <= 7}, 32'd1);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    bit we;
                    logic [RAM_AW-1:0] widx;
                    we   = 1'($urandom_range(0, 1));
                    widx = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
                    if (we) rnd_writes++;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    ldr_txn(we, widx, $urandom, r_ll, r_lc);
                    check_val("ldr_wait_bound", {31'b0, r_ll <= 7}, 32'd1);
                end
            end
        join
        @(negedge clk);
        @(negedge clk);
        check_val("rnd_we_pulses", we_cnt - w0, rnd_writes);
        check_val("rnd_led", {16'h0, led}, {16'h0, led_exp});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
